// File: rtl/mvm_stream_if.sv
// mvm_stream_if: byte-stream bundle between the UART RX/TX and mvm_stream_core.
//   s_data/s_valid/s_ready : input byte stream into the core (from UART RX)
//   m_data/m_valid/m_ready : output byte stream out of the core (to UART TX)
// Modports:
//   master : the byte source/sink that talks to the core
//   slave  : the core itself
interface mvm_stream_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid
    );

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid
    );
endinterface

// File: rtl/mvm_stream_core.sv
// mvm_stream_core: byte-stream matrix-vector multiply engine, Y = K*X.
// Header 0x01 loads R*C weights (row-major, persistent); header 0x02 loads a
// C-element vector, runs R*C serial MAC cycles, then streams R results of
// NB = ceil(W_Y_OUT/8) bytes each, LSB byte first. Any other header pulses err.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mvm_stream_if.slave (s_data/s_valid/s_ready in, m_data/m_valid/m_ready out)
//   busy : high whenever the FSM is not IDLE
//   err  : one-cycle pulse after an unknown header byte is consumed
// Optional feature macro: MVM_SIGNED_EN (two's-complement K, X and Y).
module mvm_stream_core #(
    parameter int R       = 4,
    parameter int C       = 4,
    parameter int W_X     = 4,
    parameter int W_K     = 2,
    parameter int W_Y_OUT = 10
) (
    input  logic          clk,
    input  logic          rst,
    mvm_stream_if.slave   bus,
    output logic          busy,
    output logic          err
);
    localparam int NB  = (W_Y_OUT + 7) / 8;
    localparam int KN  = R * C;
    localparam int KIW = (KN > 1) ? $clog2(KN) : 1;
    localparam int CIW = (C  > 1) ? $clog2(C)  : 1;
    localparam int RIW = (R  > 1) ? $clog2(R)  : 1;
    localparam int BIW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [KIW-1:0] K_LAST = KIW'(KN - 1);
    localparam logic [CIW-1:0] C_LAST = CIW'(C - 1);
    localparam logic [RIW-1:0] R_LAST = RIW'(R - 1);
    localparam logic [BIW-1:0] B_LAST = BIW'(NB - 1);
    localparam logic [7:0]     HDR_K  = 8'h01;
    localparam logic [7:0]     HDR_X  = 8'h02;

    typedef enum logic [2:0] {IDLE, LOAD_K, LOAD_X, COMPUTE, SEND} state_t;
    state_t state, state_nxt;

    logic [W_K-1:0]     k_mem [KN];
    logic [W_X-1:0]     x_mem [C];
    logic [W_Y_OUT-1:0] y_mem [R];
    logic [W_Y_OUT-1:0] acc;
    logic [KIW-1:0]     k_idx;      // weight write pointer in LOAD_K, read pointer in COMPUTE
    logic [CIW-1:0]     c_idx;
    logic [RIW-1:0]     r_idx;
    logic [RIW-1:0]     y_sel;      // next output element to load into m_data
    logic [BIW-1:0]     b_sel;      // next byte of that element
    logic               load_done;  // every byte has been loaded; waiting on the final handshake

    logic               s_fire, m_fire, hdr_bad;
    logic [W_Y_OUT-1:0] prod, acc_sum;
    logic [NB*8-1:0]    y_ext;
    logic [7:0]         tx_byte;

    assign bus.s_ready = !rst && (state == IDLE || state == LOAD_K || state == LOAD_X);
    assign s_fire      = bus.s_valid && bus.s_ready;
    assign m_fire      = bus.m_valid && bus.m_ready;
    assign hdr_bad     = (bus.s_data != HDR_K) && (bus.s_data != HDR_X);
    assign busy        = (state != IDLE);

    // Products are formed at accumulator width; wrap-around of the low
    // W_Y_OUT bits is identical for signed and unsigned operands.
    always_comb begin
`ifdef MVM_SIGNED_EN
        prod  = W_Y_OUT'($signed(k_mem[k_idx])) * W_Y_OUT'($signed(x_mem[c_idx]));
        y_ext = (NB*8)'($signed(y_mem[y_sel]));
`else
        prod  = W_Y_OUT'(k_mem[k_idx]) * W_Y_OUT'(x_mem[c_idx]);
        y_ext = (NB*8)'(y_mem[y_sel]);
`endif
        acc_sum = acc + prod;
        tx_byte = 8'(y_ext >> {b_sel, 3'b000});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (s_fire && bus.s_data == HDR_K)      state_nxt = LOAD_K;
                else if (s_fire && bus.s_data == HDR_X) state_nxt = LOAD_X;
            end
            LOAD_K:  if (s_fire && k_idx == K_LAST) state_nxt = IDLE;
            LOAD_X:  if (s_fire && c_idx == C_LAST) state_nxt = COMPUTE;
            COMPUTE: if (k_idx == K_LAST)           state_nxt = SEND;
            SEND:    if (m_fire && load_done)       state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < KN; i++) k_mem[i] <= '0;
            for (int unsigned i = 0; i < C; i++)  x_mem[i] <= '0;
            for (int unsigned i = 0; i < R; i++)  y_mem[i] <= '0;
            acc         <= '0;
            k_idx       <= '0;
            c_idx       <= '0;
            r_idx       <= '0;
            y_sel       <= '0;
            b_sel       <= '0;
            load_done   <= 1'b0;
            bus.m_data  <= '0;
            bus.m_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_fire && hdr_bad) err <= 1'b1;
                end
                LOAD_K: begin
                    if (s_fire) begin
                        k_mem[k_idx] <= bus.s_data[W_K-1:0];
                        k_idx        <= (k_idx == K_LAST) ? '0 : k_idx + 1'b1;
                    end
                end
                LOAD_X: begin
                    if (s_fire) begin
                        x_mem[c_idx] <= bus.s_data[W_X-1:0];
                        c_idx        <= (c_idx == C_LAST) ? '0 : c_idx + 1'b1;
                    end
                end
                COMPUTE: begin
                    k_idx <= (k_idx == K_LAST) ? '0 : k_idx + 1'b1;
                    if (c_idx == C_LAST) begin
                        y_mem[r_idx] <= acc_sum;
                        acc          <= '0;
                        c_idx        <= '0;
                        r_idx        <= (r_idx == R_LAST) ? '0 : r_idx + 1'b1;
                    end else begin
                        acc   <= acc_sum;
                        c_idx <= c_idx + 1'b1;
                    end
                end
                SEND: begin
                    // Output register refills when empty or when its byte is taken;
                    // once all bytes are loaded the final handshake just empties it.
                    if (!bus.m_valid || bus.m_ready) begin
                        if (!load_done) begin
                            bus.m_data  <= tx_byte;
                            bus.m_valid <= 1'b1;
                            if (b_sel == B_LAST) begin
                                b_sel <= '0;
                                if (y_sel == R_LAST) begin
                                    y_sel     <= '0;
                                    load_done <= 1'b1;
                                end else begin
                                    y_sel <= y_sel + 1'b1;
                                end
                            end else begin
                                b_sel <= b_sel + 1'b1;
                            end
                        end else begin
                            bus.m_valid <= 1'b0;
                            load_done   <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mvm_stream_core.md
# mvm_stream_core

Byte-stream matrix-vector multiply engine: the parametrised successor to the fixed 4×4 UART MVM datapath. It sits between the UART receiver and transmitter byte streams. Weights are loaded once and persist across any number of vector frames. Each vector frame produces Y = K·X, computed serially with one MAC per cycle, and streamed back as little-endian bytes.

## Interface
- R, 4: matrix rows / output elements
- C, 4: matrix columns / vector elements
- W_X, 4: vector element width, 1..8
- W_K, 2: weight width, 1..8
- W_Y_OUT, 10: result/accumulator width; NB = ceil(W_Y_OUT/8) output bytes per element
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s_data  in  8  input byte from UART RX
- s_valid  in  1  input byte valid
- s_ready  out  1  core accepts byte; transfer when s_valid && s_ready
- m_data  out  8  output byte to UART TX
- m_valid  out  1  output byte valid
- m_ready  in  1  TX accepts byte; transfer when m_valid && m_ready
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse on an unknown header byte

## Operation
- Frame header bytes:
  - 0x01: load weights; R*C bytes follow, row-major (K[0][0], K[0][1], …).
  - 0x02: vector; C bytes follow (X[0]..X[C-1]).
  - Any other header: byte is consumed, err pulses, state stays IDLE.
- Only the low W_K / W_X bits of each payload byte are used; upper bits are ignored.
- FSM states:
  - IDLE → LOAD_K on 0x01; IDLE → LOAD_X on 0x02.
  - LOAD_K → IDLE after R*C bytes.
  - LOAD_X → COMPUTE after C bytes.
  - COMPUTE → SEND after R*C MAC cycles.
  - SEND → IDLE after R*NB bytes transferred.
- s_ready = 1 in IDLE, LOAD_K and LOAD_X; 0 in COMPUTE and SEND.
- Weights persist until the next 0x01 frame or reset. A vector frame received before any weight load yields Y = 0.
- COMPUTE:
  - Row counter r and column counter c; acc += K[r][c]·X[c] each cycle.
  - At c = C-1: Y[r] is stored, acc clears.
- Arithmetic: default unsigned. Accumulator is W_Y_OUT bits and wraps modulo 2^W_Y_OUT; there is no saturation.
- SEND: Y[0]..Y[R-1] in order, each NB bytes, LSB byte first. Unused top bits of the last byte are zero (sign bits when MVM_SIGNED_EN is defined).
- m_data/m_valid are registered. While m_valid && !m_ready, m_data holds stable and m_valid stays high.
- A partial LOAD_K frame leaves already-written weights updated; there is no rollback.

## Timing
- Reset values:
  - State IDLE; counters 0; K and Y buffers 0; acc 0.
  - s_ready = 0 while rst is asserted, 1 in the first cycle after release.
  - m_valid = 0, m_data = 0x00, busy = 0, err = 0.
- Each accepted byte takes 1 cycle. Payload byte capture is gap-tolerant: s_valid low simply stalls the frame.
- Last X byte accepted at edge t:
  - COMPUTE occupies edges t+1..t+R*C.
  - First m_valid high after edge t+R*C+1 (17 cycles for 4×4).
- With m_ready held high, one byte transfers per cycle. The last SEND handshake returns the FSM to IDLE on the same edge; s_ready is high the next cycle.
- err is high for exactly the cycle after the unknown header is accepted.
- rst mid-frame or mid-SEND aborts immediately: m_valid drops and all state returns to reset values, weights included.

## Configuration
- MVM_SIGNED_EN undefined: K, X and Y are unsigned; SEND pads unused bits with 0.
- MVM_SIGNED_EN defined: K and X are two's complement (W_K / W_X bits) and are sign-extended before the multiply. Y is signed W_Y_OUT, sign-extended to NB*8 bits in SEND.

## Test plan
- Load K all 1, send X = {1,2,3,4} → 8 bytes 0x0A,0x00 ×4; busy low afterwards.
- Load K all 3, X all 15 → 0xB4,0x00 ×4. Send a second vector X all 0 without reloading K → 0x00 ×8 (weights persist).
- MVM_SIGNED_EN, K all 0b11 (−1), X all 0x07 → Y = −28 → 0xE4,0xFF ×4.
- Toggle m_ready randomly (about 50%) during SEND → m_data is stable while stalled, the byte sequence is identical to the no-stall run, and s_ready stays low until the last byte.
- Header 0x7F in IDLE → err pulse for 1 cycle, state IDLE. A following 0x02 frame is processed normally.
- Assert rst during the 3rd SEND byte → m_valid = 0 next cycle. A subsequent vector frame without a weight load returns all zeros.
